alu_share_arbiter: RTL and testbench

//  Shares one arithmetic_unit32-style ALU (ADD/SUB/LUI/AUIPC) between two requesters
//  (e.g. EX-stage integer op and branch/address-generation path).

---
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared ADD/SUB/LUI/AUIPC ALU.
// Each op takes one grant cycle, one execute cycle and a held valid/ready response.
module alu_share_arbiter #(
    parameter int TAG_W = 4,
    parameter bit FAIR  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [31:0]      i_req0_rs1,
    input  logic [31:0]      i_req0_rs2,
    input  logic [3:0]       i_req0_ctrl,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [31:0]      i_req1_rs1,
    input  logic [31:0]      i_req1_rs2,
    input  logic [3:0]       i_req1_ctrl,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic [31:0]      o_alu_rs1,
    output logic [31:0]      o_alu_rs2,
    output logic [3:0]       o_alu_ctrl,
    input  logic [31:0]      i_alu_result,
    input  logic             i_alu_zero,
    input  logic             i_alu_carry,
    input  logic             i_alu_negative,
    input  logic             i_alu_overflow,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic [31:0]      o_rsp_result,
    output logic [3:0]       o_rsp_flags,
    output logic             o_rsp_err,
    output logic             o_busy
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_LUI   = 4'b1010;
    localparam logic [3:0] OP_AUIPC = 4'b1011;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state, w_next;
    logic               r_rr;
    logic               r_id;
    logic [31:0]        r_rs1, r_rs2;
    logic [3:0]         r_ctrl;
    logic [TAG_W-1:0]   r_tag;
    logic               r_ill;
    logic               r_ovf_ok;
    logic [31:0]        r_rsp_result;
    logic [3:0]         r_rsp_flags;
    logic               r_rsp_err;

    logic               w_gnt, w_gnt_id;
    logic [3:0]         w_sel_ctrl;
    logic               w_sel_legal, w_sel_addsub;

    always_comb begin
        w_gnt    = 1'b0;
        w_gnt_id = 1'b0;
        if (r_state == S_IDLE) begin
            if (i_req0_valid && i_req1_valid) begin
                w_gnt    = 1'b1;
                w_gnt_id = FAIR ? r_rr : 1'b0;
            end else if (i_req0_valid) begin
                w_gnt    = 1'b1;
            end else if (i_req1_valid) begin
                w_gnt    = 1'b1;
                w_gnt_id = 1'b1;
            end
        end
    end

    assign o_req0_ready = w_gnt && !w_gnt_id;
    assign o_req1_ready = w_gnt &&  w_gnt_id;

    assign w_sel_ctrl   = w_gnt_id ? i_req1_ctrl : i_req0_ctrl;
    assign w_sel_addsub = (w_sel_ctrl == OP_ADD) || (w_sel_ctrl == OP_SUB);
    assign w_sel_legal  = w_sel_addsub || (w_sel_ctrl == OP_LUI) || (w_sel_ctrl == OP_AUIPC);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt) w_next = S_EXEC;
            S_EXEC:  w_next = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Illegal ops still burn the EXEC slot but present a benign ADD 0,0 to the ALU.
    always_comb begin
        o_alu_rs1  = 32'd0;
        o_alu_rs2  = 32'd0;
        o_alu_ctrl = OP_ADD;
        if (r_state == S_EXEC && !r_ill) begin
            o_alu_rs1  = r_rs1;
            o_alu_rs2  = r_rs2;
            o_alu_ctrl = r_ctrl;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rr         <= 1'b0;
            r_id         <= 1'b0;
            r_rs1        <= 32'd0;
            r_rs2        <= 32'd0;
            r_ctrl       <= 4'd0;
            r_tag        <= '0;
            r_ill        <= 1'b0;
            r_ovf_ok     <= 1'b0;
            r_rsp_result <= 32'd0;
            r_rsp_flags  <= 4'd0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_gnt) begin
                r_rr     <= ~w_gnt_id;
                r_id     <= w_gnt_id;
                r_rs1    <= w_gnt_id ? i_req1_rs1 : i_req0_rs1;
                r_rs2    <= w_gnt_id ? i_req1_rs2 : i_req0_rs2;
                r_ctrl   <= w_sel_ctrl;
                r_tag    <= w_gnt_id ? i_req1_tag : i_req0_tag;
                r_ill    <= !w_sel_legal;
                r_ovf_ok <= w_sel_addsub;
            end
            // Overflow is only meaningful for ADD/SUB; the ALU leaves it undefined otherwise.
            if (r_state == S_EXEC) begin
                r_rsp_err    <= r_ill;
                r_rsp_result <= r_ill ? 32'd0 : i_alu_result;
                r_rsp_flags  <= r_ill ? 4'd0 :
                                {i_alu_zero, i_alu_carry, i_alu_negative, i_alu_overflow && r_ovf_ok};
            end
        end
    end

    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_id     = r_id;
    assign o_rsp_tag    = r_tag;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_flags  = r_rsp_flags;
    assign o_rsp_err    = r_rsp_err;
    assign o_busy       = (r_state != S_IDLE);

    a_req0_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_req0_valid && !o_req0_ready) |=> i_req0_valid);
    a_req1_hold: assert property (@(posedge i_clk) disable iff (i_rst)
        (i_req1_valid && !o_req1_ready) |=> i_req1_valid);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: a fair and a fixed-priority arbiter share stimulus, each with its own ALU model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, v0, v1, rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1, t0, t1;

    logic        f_rdy0, f_rdy1, f_rv, f_id, f_err, f_busy;
    logic [31:0] f_ars1, f_ars2, f_res;
    logic [3:0]  f_actrl, f_tag, f_flg;
    logic [35:0] f_alu;
    logic        x_rdy0, x_rdy1, x_rv, x_id, x_err, x_busy;
    logic [31:0] x_ars1, x_ars2, x_res;
    logic [3:0]  x_actrl, x_tag, x_flg;
    logic [35:0] x_alu;

    // Reference ALU: {zero, carry, negative, overflow, result}; overflow is garbage (1) off ADD/SUB.
    function automatic logic [35:0] alu_f(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b1;
        case (ctrl)
            4'b0000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                           v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'b0001: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'b1010: begin r = b; end
            4'b1011: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            default: begin r = 32'd0; end
        endcase
        return {(r == 32'd0), c, r[31], v, r};
    endfunction

    assign f_alu = alu_f(f_actrl, f_ars1, f_ars2);
    assign x_alu = alu_f(x_actrl, x_ars1, x_ars2);

    alu_share_arbiter #(.TAG_W(4), .FAIR(1'b1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(f_rdy0), .i_req0_rs1(a0), .i_req0_rs2(b0), .i_req0_ctrl(c0), .i_req0_tag(t0),
        .i_req1_valid(v1), .o_req1_ready(f_rdy1), .i_req1_rs1(a1), .i_req1_rs2(b1), .i_req1_ctrl(c1), .i_req1_tag(t1),
        .o_alu_rs1(f_ars1), .o_alu_rs2(f_ars2), .o_alu_ctrl(f_actrl),
        .i_alu_result(f_alu[31:0]), .i_alu_zero(f_alu[35]), .i_alu_carry(f_alu[34]),
        .i_alu_negative(f_alu[33]), .i_alu_overflow(f_alu[32]),
        .o_rsp_valid(f_rv), .i_rsp_ready(rsp_ready), .o_rsp_id(f_id), .o_rsp_tag(f_tag),
        .o_rsp_result(f_res), .o_rsp_flags(f_flg), .o_rsp_err(f_err), .o_busy(f_busy));

    alu_share_arbiter #(.TAG_W(4), .FAIR(1'b0)) dut_fix (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(x_rdy0), .i_req0_rs1(a0), .i_req0_rs2(b0), .i_req0_ctrl(c0), .i_req0_tag(t0),
        .i_req1_valid(v1), .o_req1_ready(x_rdy1), .i_req1_rs1(a1), .i_req1_rs2(b1), .i_req1_ctrl(c1), .i_req1_tag(t1),
        .o_alu_rs1(x_ars1), .o_alu_rs2(x_ars2), .o_alu_ctrl(x_actrl),
        .i_alu_result(x_alu[31:0]), .i_alu_zero(x_alu[35]), .i_alu_carry(x_alu[34]),
        .i_alu_negative(x_alu[33]), .i_alu_overflow(x_alu[32]),
        .o_rsp_valid(x_rv), .i_rsp_ready(rsp_ready), .o_rsp_id(x_id), .o_rsp_tag(x_tag),
        .o_rsp_result(x_res), .o_rsp_flags(x_flg), .o_rsp_err(x_err), .o_busy(x_busy));

    int errs = 0;
    int checks = 0;
    int bad_ctrl = 0;

    always @(posedge clk) if (f_actrl == 4'b0101 || x_actrl == 4'b0101) bad_ctrl <= bad_ctrl + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid on one requester and return one cycle after acceptance (the EXEC cycle).
    task automatic issue(input logic req, input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] tag, output bit ok);
        ok = 1'b0;
        if (req) begin a1 = a; b1 = b; c1 = ctrl; t1 = tag; v1 = 1'b1; end
        else     begin a0 = a; b0 = b; c0 = ctrl; t0 = tag; v0 = 1'b1; end
        #1;
        for (int i = 0; i < 12 && !ok; i++) begin
            if (req ? f_rdy1 : f_rdy0) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            checks++; errs++;
            $display("FAIL grant_timeout: req%0d never saw ready", req);
        end
        tick();
        if (req) v1 = 1'b0; else v0 = 1'b0;
    endtask

    typedef struct {
        logic        req;
        logic [3:0]  ctrl;
        logic [31:0] rs1, rs2;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        int fair_ids[$];
        int fix_ids[$];
        int gnt_cyc[$];
        int both_rdy, fix_rdy1;

        vecs[0] = '{1'b0, 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 4'b0011, 1'b0};
        vecs[1] = '{1'b1, 4'b0001, 32'd3,         32'd5,         4'd1, 32'hFFFF_FFFE, 4'b0110, 1'b0};
        vecs[2] = '{1'b1, 4'b0001, 32'd5,         32'd5,         4'd2, 32'h0000_0000, 4'b1000, 1'b0};
        vecs[3] = '{1'b0, 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 4'd4, 32'h0000_0000, 4'b1100, 1'b0};
        vecs[4] = '{1'b1, 4'b1011, 32'h0000_1000, 32'h0000_2000, 4'd5, 32'h0000_3000, 4'b0000, 1'b0};
        vecs[5] = '{1'b0, 4'b0101, 32'd1,         32'd2,         4'd6, 32'h0000_0000, 4'b0000, 1'b1};
        vecs[6] = '{1'b1, 4'b0001, 32'h8000_0000, 32'd1,         4'd8, 32'h7FFF_FFFF, 4'b0001, 1'b0};

        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b1;
        a0 = '0; b0 = '0; c0 = '0; t0 = '0; a1 = '0; b1 = '0; c1 = '0; t1 = '0;
        tick(); tick(); tick();
        chk("rst_rsp_valid", 32'(f_rv), 32'd0);
        chk("rst_busy", 32'(f_busy), 32'd0);
        chk("rst_alu_ctrl", 32'(f_actrl), 32'd0);
        chk("rst_alu_rs1", f_ars1, 32'd0);
        chk("rst_rsp_result", f_res, 32'd0);
        chk("rst_rsp_flags", 32'(f_flg), 32'd0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 7; k++) begin
            issue(vecs[k].req, vecs[k].ctrl, vecs[k].rs1, vecs[k].rs2, vecs[k].tag, ok);
            chk($sformatf("v%0d_alu_ctrl", k), 32'(f_actrl), vecs[k].err ? 32'd0 : 32'(vecs[k].ctrl));
            chk($sformatf("v%0d_alu_rs1", k), f_ars1, vecs[k].err ? 32'd0 : vecs[k].rs1);
            chk($sformatf("v%0d_early_valid", k), 32'(f_rv), 32'd0);
            tick();
            chk($sformatf("v%0d_rsp_valid", k), 32'(f_rv), 32'd1);
            chk($sformatf("v%0d_result", k), f_res, vecs[k].res);
            chk($sformatf("v%0d_flags", k), 32'(f_flg), 32'(vecs[k].flg));
            chk($sformatf("v%0d_err", k), 32'(f_err), 32'(vecs[k].err));
            chk($sformatf("v%0d_id", k), 32'(f_id), 32'(vecs[k].req));
            chk($sformatf("v%0d_tag", k), 32'(f_tag), 32'(vecs[k].tag));
            tick();
            chk($sformatf("v%0d_idle", k), 32'(f_busy), 32'd0);
        end

        // LUI with a stalled consumer while the other requester waits.
        rsp_ready = 1'b0;
        issue(1'b0, 4'b1010, 32'h0000_DEAD, 32'h1234_5000, 4'd9, ok);
        a1 = 32'd1; b1 = 32'd1; c1 = 4'b0000; t1 = 4'd7; v1 = 1'b1;
        #1;
        chk("lui_exec_rdy1", 32'(f_rdy1), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lui_hold%0d_valid", k), 32'(f_rv), 32'd1);
            chk($sformatf("lui_hold%0d_result", k), f_res, 32'h1234_5000);
            chk($sformatf("lui_hold%0d_flags", k), 32'(f_flg), 32'd0);
            chk($sformatf("lui_hold%0d_tag", k), 32'(f_tag), 32'd9);
            chk($sformatf("lui_hold%0d_rdy", k), {30'd0, f_rdy1, f_rdy0}, 32'd0);
            if (k < 4) tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("after_hs_rdy1", 32'(f_rdy1), 32'd1);
        tick();
        v1 = 1'b0;
        tick();
        chk("after_hs_result", f_res, 32'd2);
        chk("after_hs_id", 32'(f_id), 32'd1);
        chk("after_hs_tag", 32'(f_tag), 32'd7);
        tick();

        // Continuous contention: fair alternates, fixed always picks req0.
        rst = 1'b1; tick(); rst = 1'b0;
        a0 = 32'd1; b0 = 32'd1; c0 = 4'b0000; t0 = 4'd1; v0 = 1'b1;
        a1 = 32'd2; b1 = 32'd2; c1 = 4'b0000; t1 = 4'd2; v1 = 1'b1;
        rsp_ready = 1'b1;
        both_rdy = 0; fix_rdy1 = 0;
        #1;
        for (int cy = 0; cy < 40 && (fair_ids.size() < 4 || fix_ids.size() < 4); cy++) begin
            if (f_rdy0 || f_rdy1) gnt_cyc.push_back(cy);
            if (f_rdy0 && f_rdy1) both_rdy++;
            if (x_rdy1) fix_rdy1++;
            if (f_rv && fair_ids.size() < 4) fair_ids.push_back(int'(f_id));
            if (x_rv && fix_ids.size() < 4) begin
                fix_ids.push_back(int'(x_id));
                chk("fix_result", x_res, 32'd2);
                chk("fix_tag", 32'(x_tag), 32'd1);
                chk("fix_flags_err", {27'd0, x_err, x_flg}, 32'd0);
            end
            tick();
        end
        chk("fair_rsp_count", 32'(fair_ids.size()), 32'd4);
        chk("fix_rsp_count", 32'(fix_ids.size()), 32'd4);
        if (fair_ids.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("fair_id%0d", i), 32'(fair_ids[i]), 32'(i % 2));
        if (fix_ids.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("fix_id%0d", i), 32'(fix_ids[i]), 32'd0);
        if (gnt_cyc.size() >= 4)
            for (int i = 1; i < 4; i++) chk($sformatf("gnt_gap%0d", i), 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
        chk("both_ready", 32'(both_rdy), 32'd0);
        chk("fix_rdy1", 32'(fix_rdy1), 32'd0);
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset mid-op, then simultaneous requests must start from req0.
        issue(1'b0, 4'b0000, 32'd1, 32'd2, 4'd1, ok);
        chk("abort_exec_busy", 32'(f_busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("abort_rsp_valid", 32'(f_rv), 32'd0);
        chk("abort_busy", {30'd0, x_busy, f_busy}, 32'd0);
        chk("abort_alu", {f_ars1 | f_ars2, 28'd0, f_actrl} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
        chk("abort_rsp_result", f_res, 32'd0);
        rst = 1'b0;
        a0 = 32'd10; b0 = 32'd20; c0 = 4'b0000; t0 = 4'd2; v0 = 1'b1;
        a1 = 32'd9;  b1 = 32'd4;  c1 = 4'b0001; t1 = 4'd3; v1 = 1'b1;
        #1;
        chk("post_rst_rdy", {30'd0, f_rdy1, f_rdy0}, 32'd1);
        chk("post_rst_fix_rdy", {30'd0, x_rdy1, x_rdy0}, 32'd1);
        tick();
        v0 = 1'b0;
        tick();
        chk("post_rst_r0_result", f_res, 32'd30);
        chk("post_rst_r0_id", 32'(f_id), 32'd0);
        tick();
        chk("post_rst_rdy1", 32'(f_rdy1), 32'd1);
        tick();
        v1 = 1'b0;
        tick();
        chk("post_rst_r1_result", f_res, 32'd5);
        chk("post_rst_r1_id", 32'(f_id), 32'd1);
        chk("post_rst_r1_tag", 32'(f_tag), 32'd3);
        tick();

        chk("alu_ctrl_0101_seen", 32'(bad_ctrl), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
